matrix_mem_responder: RTL and testbench
=======================================

// Module: matrix_mem_responder
// PURPOSE
//  Memory-side responder for the operator BRAM interface (mem_rd_en/addr/data, mem_wr_en/addr/data).
//  Holds the matrix storage array and answers operator reads/writes with fixed one-cycle latency and no stall.
//  Adds a secondary host port (loader/display) that is serviced only in cycles the operator leaves idle.
//  Sits between the matrix op engines (conv, add, mul, ...) and the top-level UI/loader logic.
// PARAMETERS
//  ELEMENT_WIDTH  `ELEMENT_WIDTH     data width of one matrix element
//  ADDR_WIDTH     `BRAM_ADDR_WIDTH   address width of both ports
//  DEPTH          2**ADDR_WIDTH      implemented words; addresses >= DEPTH are out of bounds
// PORTS
//  clk          in   1    single clock, all logic on rising edge
//  rst          in   1    asynchronous, active-high reset
//  ready        out  1    1 = clear sweep finished, ports serviced
//  op_rd_en     in   1    operator read strobe
//  op_rd_addr   in   ADDR_WIDTH     operator read address
//  op_rd_data   out  ELEMENT_WIDTH  operator read data, registered, held until next op read
//  op_wr_en     in   1    operator write strobe
//  op_wr_addr   in   ADDR_WIDTH     operator write address
//  op_wr_data   in   ELEMENT_WIDTH  operator write data
//  host_req     in   1    host request, held high until host_ack
//  host_we      in   1    1 = host write, 0 = host read (valid with host_req)
//  host_addr    in   ADDR_WIDTH     host address
//  host_wdata   in   ELEMENT_WIDTH  host write data
//  host_ack     out  1    one-cycle pulse: host access completed
//  host_rdata   out  ELEMENT_WIDTH  host read data, valid with host_ack, held afterwards
//  err_oob      out  1    sticky: an out-of-bounds access occurred (cleared by rst only)
// BEHAVIOUR
//  - Reset: ready=0, op_rd_data=0, host_ack=0, host_rdata=0, err_oob=0; FSM -> S_CLEAR, clr_ptr=0.
//  - Reset mid-operation: outputs drop immediately; in-flight host access is lost (no ack); sweep restarts at 0.
//  - S_CLEAR: writes 0 to mem[clr_ptr] each cycle, clr_ptr++; after word DEPTH-1 -> S_SERVE, ready<=1.
//    Sweep takes DEPTH cycles; all op/host inputs ignored, no ack, op_rd_data stays 0.
//  - S_SERVE op read: edge sampling op_rd_en=1 loads op_rd_data<=mem[op_rd_addr]; visible next cycle
//    (requester registering rd_en at edge k samples data at edge k+2). No rd_en -> op_rd_data holds.
//  - S_SERVE op write: edge sampling op_wr_en=1 writes mem[op_wr_addr]<=op_wr_data.
//  - Op read and op write in same cycle both performed; same address -> read returns OLD word (read-first).
//  - Host service: at an edge with host_req=1, op_rd_en=0, op_wr_en=0, host_ack=0 -> access done:
//    write mem[host_addr]<=host_wdata, or host_rdata<=mem[host_addr]; host_ack<=1 for exactly one cycle.
//  - Host starvation allowed: any op strobe defers host indefinitely; host_req must stay stable while waiting.
//  - Cycle with host_ack=1 never services a host request (forced gap; a held req is served no earlier
//    than 2 cycles after previous ack).
//  - Out of bounds (addr >= DEPTH): write dropped, read returns 0, err_oob<=1; host still gets host_ack.
//  - No arithmetic beyond address compare; data widths pass through unmodified.
//  - FSM: S_CLEAR -> S_SERVE (sweep done); S_SERVE -> S_CLEAR only via rst.
// CONFIGURATION
//  MATRIX_MEM_WR_FORWARD_EN defined: op read and op write to same in-bounds address in the same cycle
//    return NEW data (op_wr_data) on op_rd_data (write-first); host reads unaffected.
//  Not defined: read-first as above; plain BRAM inference, no bypass mux.
// TESTING
//  1 rst pulse, DEPTH=16 -> ready=0 for 16 cycles then 1; host reads of addr 0..15 all return 0x00.
//  2 op_wr_en addr 5 data 0xA7, then op_rd_en addr 5 -> op_rd_data=0xA7 one cycle after rd sampled, held.
//  3 op rd+wr addr 3 same cycle (mem[3]=0x11, wdata 0x22) -> 0x11 (0x22 with MATRIX_MEM_WR_FORWARD_EN).
//  4 host_req write 0x5C addr 9 while op_rd_en high 4 cycles -> no ack for 4 cycles, then ack pulse;
//    op read addr 9 afterwards -> 0x5C.
//  5 DEPTH=16, host read addr 20 / op write addr 17 -> host_rdata=0, host_ack pulses, err_oob=1 sticky.
//  6 rst asserted during pending host req -> host_ack never pulses, clear sweep restarts, mem all 0.

Source files
------------

// File: rtl/matrix_mem_responder.sv
// rtl/matrix_mem_responder.sv - matrix storage responder with operator port and idle-cycle host port
//
// Purpose
//   Owns the matrix storage array. After reset a clear sweep zeroes every word
//   (DEPTH cycles), then the block serves the operator BRAM-style port with a
//   fixed one-cycle read latency and no stall. A secondary host port (loader /
//   display) is serviced only in cycles where the operator issues no strobe.
//
// Parameters
//   ELEMENT_WIDTH  data width of one matrix element
//   ADDR_WIDTH     address width of both ports
//   DEPTH          implemented words; addresses >= DEPTH are out of bounds
//
// Ports
//   clk, rst       single rising-edge clock, asynchronous active-high reset
//   ready          1 once the clear sweep has finished
//   op_rd_*        operator read strobe / address / registered data (held)
//   op_wr_*        operator write strobe / address / data
//   host_req       host request, held high until host_ack
//   host_we        1 = host write, 0 = host read
//   host_addr      host address
//   host_wdata     host write data
//   host_ack       one-cycle completion pulse
//   host_rdata     host read data, valid with host_ack, held afterwards
//   err_oob        sticky out-of-bounds flag, cleared by rst only
//
// Configuration
//   MATRIX_MEM_WR_FORWARD_EN  when defined, an operator read and write to the
//   same in-bounds address in one cycle return the new write data (write-first).
//   When undefined the array is read-first with no bypass mux.

module matrix_mem_responder #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DEPTH         = 2 ** ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     op_rd_en,
    input  logic [ADDR_WIDTH-1:0]    op_rd_addr,
    output logic [ELEMENT_WIDTH-1:0] op_rd_data,
    input  logic                     op_wr_en,
    input  logic [ADDR_WIDTH-1:0]    op_wr_addr,
    input  logic [ELEMENT_WIDTH-1:0] op_wr_data,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_WIDTH-1:0]    host_addr,
    input  logic [ELEMENT_WIDTH-1:0] host_wdata,
    output logic                     host_ack,
    output logic [ELEMENT_WIDTH-1:0] host_rdata,
    output logic                     err_oob
);

    // Array index width; the upper address bits only take part in the bounds compare.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         clr_ptr_q, clr_ptr_d;
    logic                     ready_q, ready_d;
    logic [ELEMENT_WIDTH-1:0] op_rd_data_q, op_rd_data_d;
    logic                     host_ack_q, host_ack_d;
    logic [ELEMENT_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                     err_oob_q, err_oob_d;

    logic [ELEMENT_WIDTH-1:0] mem [DEPTH];

    logic                     mem_we;
    logic [IDX_W-1:0]         mem_widx;
    logic [ELEMENT_WIDTH-1:0] mem_wdata;
    logic [IDX_W-1:0]         rd_idx;
    logic [ELEMENT_WIDTH-1:0] rd_word;

    logic op_rd_oob;
    logic op_wr_oob;
    logic host_oob;
    logic host_go;

    assign op_rd_oob = ({1'b0, op_rd_addr} >= DEPTH_W);
    assign op_wr_oob = ({1'b0, op_wr_addr} >= DEPTH_W);
    assign host_oob  = ({1'b0, host_addr}  >= DEPTH_W);

    // Host is served only when the operator is idle this cycle and the previous
    // cycle was not itself an ack; the ack cycle acts as a forced gap so a held
    // request cannot be double-serviced.
    assign host_go = (state_q == S_SERVE) && host_req && !op_rd_en && !op_wr_en && !host_ack_q;

    // Op and host reads never coincide, so one read port is shared.
    assign rd_idx  = host_go ? host_addr[IDX_W-1:0] : op_rd_addr[IDX_W-1:0];
    assign rd_word = mem[rd_idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clr_ptr_q    <= '0;
            ready_q      <= 1'b0;
            op_rd_data_q <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            err_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            ready_q      <= ready_d;
            op_rd_data_q <= op_rd_data_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            err_oob_q    <= err_oob_d;
        end
    end

    // Next-state logic: leaving S_CLEAR only after the last word is zeroed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_ptr_q == LAST_IDX) state_d = S_SERVE;
            S_SERVE: state_d = S_SERVE;
            default: state_d = S_CLEAR;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        mem_we       = 1'b0;
        mem_widx     = clr_ptr_q;
        mem_wdata    = '0;
        clr_ptr_d    = clr_ptr_q;
        ready_d      = ready_q;
        op_rd_data_d = op_rd_data_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        err_oob_d    = err_oob_q;

        case (state_q)
            S_CLEAR: begin
                // All port inputs are ignored while the sweep runs.
                mem_we    = 1'b1;
                mem_widx  = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + IDX_W'(1);
                ready_d   = (clr_ptr_q == LAST_IDX);
            end

            S_SERVE: begin
                ready_d = 1'b1;

                if (op_rd_en) begin
                    if (op_rd_oob) begin
                        op_rd_data_d = '0;
                        err_oob_d    = 1'b1;
                    end else begin
                        op_rd_data_d = rd_word;
`ifdef MATRIX_MEM_WR_FORWARD_EN
                        if (op_wr_en && !op_wr_oob && (op_wr_addr == op_rd_addr)) begin
                            op_rd_data_d = op_wr_data;
                        end
`endif
                    end
                end

                if (op_wr_en) begin
                    if (op_wr_oob) begin
                        err_oob_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_widx  = op_wr_addr[IDX_W-1:0];
                        mem_wdata = op_wr_data;
                    end
                end

                // host_go excludes any op strobe, so the write port is free here.
                if (host_go) begin
                    host_ack_d = 1'b1;
                    if (host_oob) begin
                        err_oob_d = 1'b1;
                        if (!host_we) host_rdata_d = '0;
                    end else if (host_we) begin
                        mem_we    = 1'b1;
                        mem_widx  = host_addr[IDX_W-1:0];
                        mem_wdata = host_wdata;
                    end else begin
                        host_rdata_d = rd_word;
                    end
                end
            end

            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // Storage array: no reset so it maps onto block RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign ready      = ready_q;
    assign op_rd_data = op_rd_data_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign err_oob    = err_oob_q;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// tb/tb_matrix_mem_responder.sv - directed scoreboard bench for matrix_mem_responder
module tb_matrix_mem_responder;

    localparam int EW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready;
    logic          op_rd_en = 1'b0;
    logic [AW-1:0] op_rd_addr = '0;
    logic [EW-1:0] op_rd_data;
    logic          op_wr_en = 1'b0;
    logic [AW-1:0] op_wr_addr = '0;
    logic [EW-1:0] op_wr_data = '0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [EW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [EW-1:0] host_rdata;
    logic          err_oob;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] model [DEPTH];
    logic [EW-1:0] exp_q [$];

    matrix_mem_responder #(
        .ELEMENT_WIDTH(EW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .op_rd_en  (op_rd_en),
        .op_rd_addr(op_rd_addr),
        .op_rd_data(op_rd_data),
        .op_wr_en  (op_wr_en),
        .op_wr_addr(op_wr_addr),
        .op_wr_data(op_wr_data),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_ack  (host_ack),
        .host_rdata(host_rdata),
        .err_oob   (err_oob)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] model_rd(input logic [AW-1:0] a);
        int idx;
        idx = int'(a);
        return (idx < DEPTH) ? model[idx] : '0;
    endfunction

    task automatic model_wr(input logic [AW-1:0] a, input logic [EW-1:0] d);
        int idx;
        idx = int'(a);
        if (idx < DEPTH) model[idx] = d;
    endtask

    task automatic op_write(input logic [AW-1:0] a, input logic [EW-1:0] d);
        @(negedge clk);
        op_wr_en = 1'b1; op_wr_addr = a; op_wr_data = d;
        cyc();
        op_wr_en = 1'b0;
        model_wr(a, d);
    endtask

    task automatic op_read(input logic [AW-1:0] a, input string tag);
        exp_q.push_back(model_rd(a));
        @(negedge clk);
        op_rd_en = 1'b1; op_rd_addr = a;
        cyc();
        op_rd_en = 1'b0;
        check(tag, 32'(op_rd_data), 32'(exp_q.pop_front()));
    endtask

    task automatic op_rdwr(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                           input logic [EW-1:0] wd, input string tag);
        logic [EW-1:0] e;
        e = model_rd(ra);
`ifdef MATRIX_MEM_WR_FORWARD_EN
        if (ra == wa && int'(ra) < DEPTH) e = wd;
`endif
        exp_q.push_back(e);
        @(negedge clk);
        op_rd_en = 1'b1; op_rd_addr = ra;
        op_wr_en = 1'b1; op_wr_addr = wa; op_wr_data = wd;
        cyc();
        op_rd_en = 1'b0; op_wr_en = 1'b0;
        model_wr(wa, wd);
        check(tag, 32'(op_rd_data), 32'(exp_q.pop_front()));
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] a,
                               input logic [EW-1:0] wd, input string tag);
        logic got;
        if (!we) exp_q.push_back(model_rd(a));
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc();
            if (host_ack === 1'b1) got = 1'b1;
        end
        host_req = 1'b0;
        check({tag, "_ack"}, 32'(got), 32'(1));
        if (!we) check({tag, "_rdata"}, 32'(host_rdata), 32'(exp_q.pop_front()));
        else model_wr(a, wd);
    endtask

    initial begin
        logic ack_seen;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_op_rd_data", 32'(op_rd_data), 32'(0));
        check("rst_host_ack", 32'(host_ack), 32'(0));
        check("rst_host_rdata", 32'(host_rdata), 32'(0));
        check("rst_err_oob", 32'(err_oob), 32'(0));

        // Clear sweep: op strobes during the sweep must be ignored
        @(negedge clk);
        rst = 1'b0;
        op_rd_en = 1'b1; op_rd_addr = 5'd3;
        op_wr_en = 1'b1; op_wr_addr = 5'd3; op_wr_data = 8'hFF;
        for (int i = 1; i <= DEPTH; i++) begin
            cyc();
            if (i == 1)  check("sweep_ready_c1", 32'(ready), 32'(0));
            if (i == 15) check("sweep_ready_c15", 32'(ready), 32'(0));
            if (i == 15) check("sweep_op_rd_data", 32'(op_rd_data), 32'(0));
            if (i == 16) check("sweep_ready_c16", 32'(ready), 32'(1));
        end
        op_rd_en = 1'b0; op_wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) host_access(1'b0, AW'(i), '0, "clr_host_rd");

        // Op write then read, data held afterwards
        op_write(5'd5, 8'hA7);
        op_read(5'd5, "op_rd_5");
        cyc();
        check("op_rd_hold", 32'(op_rd_data), 32'(8'hA7));

        // Same-cycle read and write
        op_write(5'd3, 8'h11);
        op_rdwr(5'd3, 5'd3, 8'h22, "rdwr_same_3");
        op_read(5'd3, "rd_after_rdwr_3");
        op_rdwr(5'd5, 5'd6, 8'h66, "rdwr_diff_5_6");
        op_read(5'd6, "rd_6");

        // Host write starved by 4 cycles of op reads
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd9; host_wdata = 8'h5C;
        op_rd_en = 1'b1; op_rd_addr = 5'd5;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model_rd(5'd5));
            cyc();
            check("starve_no_ack", 32'(host_ack), 32'(0));
            check("starve_op_rd", 32'(op_rd_data), 32'(exp_q.pop_front()));
        end
        @(negedge clk);
        op_rd_en = 1'b0;
        cyc();
        check("starve_ack", 32'(host_ack), 32'(1));
        host_req = 1'b0;
        model_wr(5'd9, 8'h5C);
        cyc();
        check("ack_pulse_one", 32'(host_ack), 32'(0));
        op_read(5'd9, "op_rd_9");

        // Held host read: forced gap between back-to-back services
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd5;
        exp_q.push_back(model_rd(5'd5));
        cyc();
        check("gap_ack1", 32'(host_ack), 32'(1));
        check("gap_rdata", 32'(host_rdata), 32'(exp_q.pop_front()));
        cyc();
        check("gap_no_ack", 32'(host_ack), 32'(0));
        cyc();
        check("gap_ack2", 32'(host_ack), 32'(1));
        host_req = 1'b0;

        // Out of bounds
        check("oob_clear", 32'(err_oob), 32'(0));
        op_write(5'd1, 8'h33);
        check("oob_still_clear", 32'(err_oob), 32'(0));
        op_write(5'd17, 8'hEE);
        check("oob_op_wr", 32'(err_oob), 32'(1));
        op_read(5'd1, "oob_no_alias_1");
        op_read(5'd18, "oob_op_rd_18");
        host_access(1'b0, 5'd9, '0, "host_rd_9");
        host_access(1'b0, 5'd20, '0, "host_rd_20");
        host_access(1'b1, 5'd31, 8'h99, "host_wr_31");
        op_read(5'd15, "oob_no_alias_15");
        check("oob_sticky", 32'(err_oob), 32'(1));

        // Reset during a pending (starved) host request
        @(negedge clk);
        op_rd_en = 1'b1; op_rd_addr = 5'd5;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd4; host_wdata = 8'h77;
        cyc();
        check("pend_no_ack", 32'(host_ack), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("async_ready", 32'(ready), 32'(0));
        check("async_op_rd_data", 32'(op_rd_data), 32'(0));
        check("async_err_oob", 32'(err_oob), 32'(0));
        check("async_host_rdata", 32'(host_rdata), 32'(0));
        op_rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack_seen = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            cyc();
            if (host_ack === 1'b1) ack_seen = 1'b1;
            if (i == 15) check("resweep_ready_c15", 32'(ready), 32'(0));
            if (i == 16) check("resweep_ready_c16", 32'(ready), 32'(1));
        end
        host_req = 1'b0;
        cyc();
        if (host_ack === 1'b1) ack_seen = 1'b1;
        check("rst_lost_ack", 32'(ack_seen), 32'(0));
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) host_access(1'b0, AW'(i), '0, "reclr_host_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
